ntt_result_streamer: RTL and testbench
======================================

Name: ntt_result_streamer

Overview:
Downstream stage of the NTT engine. It takes BRAM port B after the engine's ntt_done level rises and reads back the N transformed coefficients in address order. The coefficients go out on a valid/ready stream toward the PS-side DMA/FIFO. A small credit-controlled output FIFO absorbs BRAM read latency and downstream backpressure.

Parameters:
DATA_W, 64, coefficient/BRAM word width
ADDR_W, 10, BRAM address width
N_COEFFS, 1024, coefficients per transform; legal range 1..2^ADDR_W
BASE_ADDR, 0, BRAM address of coefficient 0
RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2

Ports:
clk  in  1  system clock (PL clock)
rst  in  1  synchronous, active-high reset
ntt_done  in  1  engine done level; a rising edge starts a stream
BRAM_addr  out  ADDR_W  port B address
BRAM_clk  out  1  driven from clk
BRAM_din  out  DATA_W  tied 0
BRAM_dout  in  DATA_W  port B read data
BRAM_en  out  1  port B enable (read strobe)
BRAM_rst  out  1  driven from rst
BRAM_we  out  1  tied 0 (read-only)
m_data  out  DATA_W  coefficient
m_valid  out  1  m_data valid
m_ready  in  1  sink accepts when m_valid & m_ready
m_last  out  1  marks coefficient N_COEFFS-1
busy  out  1  high in states READ and DRAIN
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset is synchronous and active-high. One clock, clk.
- Reset values: state IDLE, m_valid 0, m_last 0, BRAM_en 0, BRAM_addr 0, busy 0, done 0. FIFO count, in-flight count, issue count and accept count are all 0. The edge register ntt_done_q resets to 1, so a level that is already high at reset release never triggers a stream.
- m_data is don't-care whenever m_valid=0.
- Trigger: trig = ntt_done & ~ntt_done_q. It is honoured only in IDLE; triggers in any other state are ignored.
- State IDLE: go to READ on trig.
- State READ, read issue:
  - BRAM_en=1 and BRAM_addr=(BASE_ADDR+issue_cnt) mod 2^ADDR_W when issue_cnt<N_COEFFS and fifo_cnt+inflight<FIFO_DEPTH.
  - Each issue increments issue_cnt.
  - The cycle issuing index N_COEFFS-1 moves the FSM to DRAIN.
- Read return: data issued in cycle c is valid on BRAM_dout in cycle c+RD_LAT. It is written into the FIFO at the end of that cycle. in-flight counts issued reads that have not yet been written.
- The credit rule guarantees no FIFO overflow. A write with a full FIFO is an assertion failure.
- State DRAIN: go to DONE when accept_cnt reaches N_COEFFS. The FIFO and in-flight counts are 0 at that point.
- State DONE: done=1 for exactly one cycle, then IDLE.
- Output stream:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_last = m_valid & (accept_cnt==N_COEFFS-1).
  - m_data and m_last hold stable while m_valid & ~m_ready.
  - A FIFO push and pop in the same cycle leave the count unchanged.
- Latency and throughput:
  - Edge sampled at the end of cycle t → READ and first BRAM_en in t+1 → first m_valid in t+2+RD_LAT.
  - With m_ready held 1, one beat per cycle.
  - Last beat accepted in cycle L → done in L+1, busy low in L+1.
- Address wrap: the address is computed mod 2^ADDR_W. No error is raised on wrap.
- Reset mid-operation returns to the reset values on the next cycle. The FIFO is flushed, and returning BRAM data from reads in flight is discarded.
- The BRAM is never written.

Test Plan:
- BRAM preloaded with word[a]=3a+7, defaults, m_ready=1, ntt_done rises in cycle t:
  - BRAM_en first asserted in t+1; m_valid first in t+3 with data 7.
  - 1024 beats with values 3i+7 in order.
  - m_last only on beat 1023 (value 3076); done pulse one cycle after it; busy low thereafter.
- Backpressure with m_ready random at 50%, plus m_ready held 0 for 20 cycles mid-stream:
  - No lost or duplicated beats.
  - fifo_cnt+inflight never exceeds 4; BRAM_en stays low while credits are exhausted.
  - m_data stable during stalls.
- Wrap with BASE_ADDR=1020, N_COEFFS=8:
  - BRAM_addr sequence 1020,1021,1022,1023,0,1,2,3.
  - Stream data matches those words; m_last on the 8th beat.
- Trigger handling:
  - ntt_done held 1 through reset release → no BRAM_en for 50 cycles.
  - A fresh 0→1 on ntt_done starts a stream; a toggle during READ is ignored.
  - A rising edge after done starts a second complete stream.
- Reset asserted after 100 accepted beats:
  - Next cycle: m_valid=0, BRAM_en=0, busy=0.
  - A new trigger restarts at address BASE_ADDR with beat 0.
- RD_LAT=2, N_COEFFS=1:
  - Single BRAM_en in t+1; m_valid in t+4 with m_last=1; done one cycle after acceptance.

Source files
------------

// File: rtl/ntt_result_streamer.sv
// Streams the NTT result coefficients out of BRAM port B onto a valid/ready bus.
// Reads are credit-limited so the small output FIFO can never overflow.
module ntt_result_streamer #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 10,
    parameter int N_COEFFS   = 1024,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ntt_done,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic              BRAM_clk,
    output logic [DATA_W-1:0] BRAM_din,
    input  logic [DATA_W-1:0] BRAM_dout,
    output logic              BRAM_en,
    output logic              BRAM_rst,
    output logic              BRAM_we,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  N_ALL   = CNT_W'(N_COEFFS);
    localparam logic [CNT_W-1:0]  N_LAST  = CNT_W'(N_COEFFS - 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [FC_W:0]     DEPTH_C = (FC_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic              ntt_done_q;
    logic              trig;
    logic              start;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  accept_cnt;
    logic [FC_W-1:0]   fifo_cnt;
    logic [FC_W-1:0]   inflight;
    logic [RD_LAT-1:0] rd_pipe;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    assign trig  = ntt_done & ~ntt_done_q;
    assign push  = rd_pipe[RD_LAT-1];
    assign pop   = m_valid & m_ready;
    // Credits cover both buffered words and reads still in the BRAM pipe
    assign issue = (state == READ) && (issue_cnt < N_ALL) &&
                   (({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C);

    assign BRAM_clk  = clk;
    assign BRAM_rst  = rst;
    assign BRAM_din  = '0;
    assign BRAM_we   = 1'b0;
    assign BRAM_en   = issue;
    assign BRAM_addr = issue ? BASE_A + issue_cnt[ADDR_W-1:0] : '0;

    assign m_valid = (fifo_cnt != '0);
    assign m_data  = mem[rd_ptr];
    assign m_last  = m_valid && (accept_cnt == N_LAST);

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    state_nx = READ;
                    start    = 1'b1;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issue && issue_cnt == N_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && accept_cnt == N_LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ntt_done_q <= 1'b1;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            fifo_cnt   <= '0;
            inflight   <= '0;
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nx;
            ntt_done_q <= ntt_done;
            if (start) begin
                issue_cnt  <= '0;
                accept_cnt <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
                if (pop) accept_cnt <= accept_cnt + CNT_W'(1);
            end
            rd_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            inflight <= inflight + FC_W'(issue) - FC_W'(push);
            fifo_cnt <= fifo_cnt + FC_W'(push) - FC_W'(pop);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= BRAM_dout;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (fifo_cnt != FC_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ntt_result_streamer.sv
// Randomized bench for ntt_result_streamer: three configurations checked
// against a beat-level scoreboard built from the BRAM contents 3a+7.
module tb_ntt_result_streamer;
    localparam int NI = 3;
    localparam int NC [NI]   = '{1024, 8, 1};
    localparam int BASE [NI] = '{0, 1020, 0};
    localparam int LAT [NI]  = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        nd    [NI];
    logic        mr    [NI];
    logic [9:0]  addr  [NI];
    logic        bclk  [NI];
    logic [63:0] bdin  [NI];
    logic [63:0] dout  [NI];
    logic        en    [NI];
    logic        brst  [NI];
    logic        bwe   [NI];
    logic [63:0] md    [NI];
    logic        mv    [NI];
    logic        ml    [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [63:0] q1    [NI];
    logic [63:0] q2    [NI];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit rand_mode = 0;
    bit hold      = 0;

    int start_id [NI] = '{0, 0, 0};
    int seen_id  [NI] = '{0, 0, 0};
    int t_trig   [NI];
    int iss      [NI];
    int acc      [NI];
    int first_en [NI];
    int first_mv [NI];
    int last_cyc [NI];
    bit stall_q  [NI];
    bit done_q   [NI];
    logic [63:0] hold_d [NI];
    logic        hold_l [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_result_streamer u0 (
        .clk(clk), .rst(rst), .ntt_done(nd[0]), .BRAM_addr(addr[0]),
        .BRAM_clk(bclk[0]), .BRAM_din(bdin[0]), .BRAM_dout(dout[0]),
        .BRAM_en(en[0]), .BRAM_rst(brst[0]), .BRAM_we(bwe[0]),
        .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_last(ml[0]),
        .busy(busy[0]), .done(done[0])
    );

    ntt_result_streamer #(.BASE_ADDR(1020), .N_COEFFS(8)) u1 (
        .clk(clk), .rst(rst), .ntt_done(nd[1]), .BRAM_addr(addr[1]),
        .BRAM_clk(bclk[1]), .BRAM_din(bdin[1]), .BRAM_dout(dout[1]),
        .BRAM_en(en[1]), .BRAM_rst(brst[1]), .BRAM_we(bwe[1]),
        .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_last(ml[1]),
        .busy(busy[1]), .done(done[1])
    );

    ntt_result_streamer #(.RD_LAT(2), .N_COEFFS(1)) u2 (
        .clk(clk), .rst(rst), .ntt_done(nd[2]), .BRAM_addr(addr[2]),
        .BRAM_clk(bclk[2]), .BRAM_din(bdin[2]), .BRAM_dout(dout[2]),
        .BRAM_en(en[2]), .BRAM_rst(brst[2]), .BRAM_we(bwe[2]),
        .m_data(md[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_last(ml[2]),
        .busy(busy[2]), .done(done[2])
    );

    function automatic logic [63:0] word(input int a);
        return 64'(3 * a + 7);
    endfunction

    // Synchronous-read BRAM, optionally with an output register
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (en[k]) q1[k] <= word(int'(addr[k]));
            q2[k] <= q1[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) dout[k] = (LAT[k] == 2) ? q2[k] : q1[k];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++)
                mr[k] = rand_mode ? (hold ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
        end
    end

    // Scoreboard: addresses, credits, beat order, stall stability, done timing
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst || seen_id[k] != start_id[k]) begin
                seen_id[k]  = start_id[k];
                iss[k]      = 0;
                acc[k]      = 0;
                first_en[k] = -1;
                first_mv[k] = -1;
                last_cyc[k] = -100;
                stall_q[k]  = 0;
                done_q[k]   = 0;
            end
            if (!rst) begin
                if (en[k]) begin
                    if (first_en[k] < 0) first_en[k] = cyc;
                    chk($sformatf("u%0d.addr", k), 64'(addr[k]),
                        64'((BASE[k] + iss[k]) % 1024));
                    chk($sformatf("u%0d.over_issue", k), 64'(iss[k] < NC[k]), 1);
                    chk($sformatf("u%0d.credit", k), 64'(iss[k] - acc[k] < 4), 1);
                    iss[k]++;
                end
                if (mv[k] && first_mv[k] < 0) first_mv[k] = cyc;
                if (stall_q[k]) begin
                    chk($sformatf("u%0d.stall_valid", k), 64'(mv[k]), 1);
                    chk($sformatf("u%0d.stall_data", k), md[k], hold_d[k]);
                    chk($sformatf("u%0d.stall_last", k), 64'(ml[k]), 64'(hold_l[k]));
                end
                if (mv[k] && mr[k]) begin
                    chk($sformatf("u%0d.data", k), md[k],
                        word((BASE[k] + acc[k]) % 1024));
                    chk($sformatf("u%0d.last", k), 64'(ml[k]),
                        64'(acc[k] == NC[k] - 1));
                    chk($sformatf("u%0d.busy_beat", k), 64'(busy[k]), 1);
                    acc[k]++;
                    last_cyc[k] = cyc;
                end
                if (done_q[k]) chk($sformatf("u%0d.done_pulse", k), 64'(done[k]), 0);
                if (done[k]) begin
                    chk($sformatf("u%0d.done_lat", k), 64'(cyc - last_cyc[k]), 1);
                    chk($sformatf("u%0d.done_beats", k), 64'(acc[k]), 64'(NC[k]));
                    chk($sformatf("u%0d.done_issues", k), 64'(iss[k]), 64'(NC[k]));
                    chk($sformatf("u%0d.done_busy", k), 64'(busy[k]), 0);
                end
                stall_q[k] = mv[k] && !mr[k];
                hold_d[k]  = md[k];
                hold_l[k]  = ml[k];
                done_q[k]  = done[k];
            end
        end
    end

    task automatic trigger(input int k);
        @(posedge clk);
        #1 nd[k] = 1'b0;
        @(posedge clk);
        #1;
        start_id[k]++;
        t_trig[k] = cyc;
        nd[k] = 1'b1;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[k] && n < budget);
        chk($sformatf("u%0d.done_timeout", k), 64'(done[k]), 1);
    endtask

    task automatic wait_acc(input int k, input int beats, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acc[k] < beats && n < budget);
        chk($sformatf("u%0d.acc_timeout", k), 64'(acc[k] >= beats), 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        nd  = '{1'b1, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.rst_valid", k), 64'(mv[k]), 0);
            chk($sformatf("u%0d.rst_last", k), 64'(ml[k]), 0);
            chk($sformatf("u%0d.rst_en", k), 64'(en[k]), 0);
            chk($sformatf("u%0d.rst_addr", k), 64'(addr[k]), 0);
            chk($sformatf("u%0d.rst_busy", k), 64'(busy[k]), 0);
            chk($sformatf("u%0d.rst_done", k), 64'(done[k]), 0);
            chk($sformatf("u%0d.we", k), 64'(bwe[k]), 0);
            chk($sformatf("u%0d.din", k), bdin[k], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (en[0]) n++;
        end
        chk("held_level_no_en", 64'(n), 0);

        // Full stream with m_ready high; a toggle during READ must be ignored
        trigger(0);
        repeat (10) @(posedge clk);
        #1 nd[0] = 1'b0;
        @(posedge clk);
        #1 nd[0] = 1'b1;
        wait_done(0, 3000);
        chk("en_latency", 64'(first_en[0] - t_trig[0]), 1);
        chk("valid_latency", 64'(first_mv[0] - t_trig[0]), 3);
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy[0]), 0);
        chk("idle_en", 64'(en[0]), 0);

        // Second stream under random backpressure with a long stall
        rand_mode = 1;
        trigger(0);
        wait_acc(0, 300, 3000);
        hold = 1;
        repeat (20) @(posedge clk);
        hold = 0;
        wait_done(0, 6000);
        rand_mode = 0;

        // Reset after 100 beats, then restart from beat 0
        trigger(0);
        wait_acc(0, 100, 2000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(mv[0]), 0);
        chk("mid_rst_en", 64'(en[0]), 0);
        chk("mid_rst_busy", 64'(busy[0]), 0);
        @(negedge clk);
        chk("mid_rst_flush", 64'(mv[0]), 0);
        trigger(0);
        wait_done(0, 3000);
        chk("restart_en_latency", 64'(first_en[0] - t_trig[0]), 1);

        // Address wrap configuration
        trigger(1);
        wait_done(1, 200);
        chk("u1.en_latency", 64'(first_en[1] - t_trig[1]), 1);

        // Two-cycle read latency with a single coefficient
        trigger(2);
        wait_done(2, 50);
        chk("u2.en_latency", 64'(first_en[2] - t_trig[2]), 1);
        chk("u2.valid_latency", 64'(first_mv[2] - t_trig[2]), 4);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
